// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and encodings for the RV32 subset control path (ADD, SUB, ADDI).
//   seq_state_t : sequencer FSM states
//   alu_op_t    : ALU operation select driven to the datapath
//   fault_t     : sticky fault code reported by the sequencer
//   OP_*/F3_*/F7_* : opcode / funct3 / funct7 encodings recognised by the decoder
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    ALU_NONE = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_t;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [2:0]  F3_ADD    = 3'b000;
  localparam logic [6:0]  F7_ADD    = 7'b0000000;
  localparam logic [6:0]  F7_SUB    = 7'b0100000;
  // The all-zero word marks a normal end of program.
  localparam logic [31:0] INSTR_END = 32'h0000_0000;

endpackage

// File: rtl/cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_if
// Control bus between the sequencer and the datapath / instruction memory.
//   start, instr_ready, instruction         : datapath -> sequencer
//   instr_req, ir_load, pc_inc, reg_we,
//   alu_op, use_imm, halted, fault          : sequencer -> datapath
//   cycle_count, retired_count              : performance counters, present only
//                                             when CPU_SEQ_PERF_EN is defined
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic        start;
  logic        instr_req;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        ir_load;
  logic        pc_inc;
  logic        reg_we;
  alu_op_t     alu_op;
  logic        use_imm;
  logic        halted;
  fault_t      fault;

`ifdef CPU_SEQ_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  modport master (
    input  start, instr_ready, instruction,
    output instr_req, ir_load, pc_inc, reg_we, alu_op, use_imm, halted, fault,
    output cycle_count, retired_count
  );

  modport slave (
    output start, instr_ready, instruction,
    input  instr_req, ir_load, pc_inc, reg_we, alu_op, use_imm, halted, fault,
    input  cycle_count, retired_count
  );
`else
  modport master (
    input  start, instr_ready, instruction,
    output instr_req, ir_load, pc_inc, reg_we, alu_op, use_imm, halted, fault
  );

  modport slave (
    output start, instr_ready, instruction,
    input  instr_req, ir_load, pc_inc, reg_we, alu_op, use_imm, halted, fault
  );
`endif

endinterface

// File: rtl/cpu_decoder.sv
// -----------------------------------------------------------------------------
// cpu_decoder
// Purely combinational classifier for the RV32 subset.
//   i_instruction : instruction register contents
//   o_alu_op      : ALU_ADD for ADD/ADDI, ALU_SUB for SUB, else ALU_NONE
//   o_use_imm     : operand B is the sign-extended I-immediate (ADDI)
//   o_writes_rd   : legal instruction whose rd is not x0
//   o_is_illegal  : anything outside the subset (except the end marker)
//   o_is_end      : all-zero end-of-program word
// -----------------------------------------------------------------------------
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] i_instruction,
  output alu_op_t     o_alu_op,
  output logic        o_use_imm,
  output logic        o_writes_rd,
  output logic        o_is_illegal,
  output logic        o_is_end
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic       w_unused;

  assign w_opcode = i_instruction[6:0];
  assign w_funct3 = i_instruction[14:12];
  assign w_funct7 = i_instruction[31:25];
  assign w_rd     = i_instruction[11:7];
  // Register-select fields matter only to the datapath, not to classification.
  assign w_unused = ^i_instruction[24:15];

  // NOTE: every output gets a default before the if-chain, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    o_alu_op     = ALU_NONE;
    o_use_imm    = 1'b0;
    o_writes_rd  = 1'b0;
    o_is_illegal = 1'b0;
    o_is_end     = 1'b0;

    if (i_instruction == INSTR_END) begin
      o_is_end = 1'b1;
    end else if (w_opcode == OP_R && w_funct3 == F3_ADD && w_funct7 == F7_ADD) begin
      o_alu_op    = ALU_ADD;
      o_writes_rd = (w_rd != 5'd0);
    end else if (w_opcode == OP_R && w_funct3 == F3_ADD && w_funct7 == F7_SUB) begin
      o_alu_op    = ALU_SUB;
      o_writes_rd = (w_rd != 5'd0);
    end else if (w_opcode == OP_I && w_funct3 == F3_ADD) begin
      o_alu_op    = ALU_ADD;
      o_use_imm   = 1'b1;
      o_writes_rd = (w_rd != 5'd0);
    end else begin
      o_is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK
// -> FETCH ..., ending in HALT on the end marker, an illegal instruction or a
// memory timeout. All enables except ir_load are registered.
//   MEM_TIMEOUT : FETCH cycles without instr_ready before a timeout halt
//   clock       : rising-edge clock
//   reset       : asynchronous, active-low
//   seq_bus     : cpu_sequencer_if.master (handshake, enables, status)
// Optional feature (macro CPU_SEQ_PERF_EN): 32-bit cycle_count (cycles spent
// outside IDLE/HALT) and retired_count (WRITEBACKs) on seq_bus.
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  cpu_sequencer_if.master seq_bus
);

  localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_instr_req;
  logic             r_pc_inc;
  logic             r_reg_we;
  alu_op_t          r_alu_op;
  logic             r_use_imm;
  logic             r_halted;
  fault_t           r_fault;
  logic             r_dec_writes_rd;

  alu_op_t          w_alu_op;
  logic             w_use_imm;
  logic             w_writes_rd;
  logic             w_is_illegal;
  logic             w_is_end;
  logic [CNT_W-1:0] w_wait_next;

  cpu_decoder u_decoder (
    .i_instruction (seq_bus.instruction),
    .o_alu_op      (w_alu_op),
    .o_use_imm     (w_use_imm),
    .o_writes_rd   (w_writes_rd),
    .o_is_illegal  (w_is_illegal),
    .o_is_end      (w_is_end)
  );

  // Saturating increment; the FSM leaves FETCH before it could ever wrap.
  assign w_wait_next = (r_wait_cnt == TIMEOUT_V) ? r_wait_cnt
                                                 : r_wait_cnt + CNT_W'(1);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_wait_cnt      <= '0;
      r_instr_req     <= 1'b0;
      r_pc_inc        <= 1'b0;
      r_reg_we        <= 1'b0;
      r_alu_op        <= ALU_NONE;
      r_use_imm       <= 1'b0;
      r_halted        <= 1'b0;
      r_fault         <= FAULT_NONE;
      r_dec_writes_rd <= 1'b0;
    end else begin
      // Write/advance strobes are one-cycle pulses raised only on entry to WRITEBACK.
      r_pc_inc <= 1'b0;
      r_reg_we <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (seq_bus.start) begin
            r_state     <= S_FETCH;
            r_instr_req <= 1'b1;
          end
        end

        S_FETCH: begin
          // Ready wins over a timeout landing in the same cycle.
          if (seq_bus.instr_ready) begin
            r_wait_cnt  <= '0;
            r_instr_req <= 1'b0;
            r_state     <= S_DECODE;
          end else begin
            r_wait_cnt <= w_wait_next;
            if (w_wait_next == TIMEOUT_V) begin
              r_instr_req <= 1'b0;
              r_halted    <= 1'b1;
              r_fault     <= FAULT_TIMEOUT;
              r_state     <= S_HALT;
            end
          end
        end

        S_DECODE: begin
          if (w_is_end) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_is_illegal) begin
            r_halted <= 1'b1;
            r_fault  <= FAULT_ILLEGAL;
            r_state  <= S_HALT;
          end else begin
            r_alu_op        <= w_alu_op;
            r_use_imm       <= w_use_imm;
            r_dec_writes_rd <= w_writes_rd;
            r_state         <= S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          // Operands settle here; the write and PC advance follow together.
          r_reg_we <= r_dec_writes_rd;
          r_pc_inc <= 1'b1;
          r_state  <= S_WRITEBACK;
        end

        S_WRITEBACK: begin
          r_alu_op    <= ALU_NONE;
          r_use_imm   <= 1'b0;
          r_instr_req <= 1'b1;
          r_state     <= S_FETCH;
        end

        S_HALT: begin
          // Only reset leaves HALT.
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign seq_bus.instr_req = r_instr_req;
  // Capture must happen on the same edge the memory data is valid.
  assign seq_bus.ir_load   = (r_state == S_FETCH) && seq_bus.instr_ready;
  assign seq_bus.pc_inc    = r_pc_inc;
  assign seq_bus.reg_we    = r_reg_we;
  assign seq_bus.alu_op    = r_alu_op;
  assign seq_bus.use_imm   = r_use_imm;
  assign seq_bus.halted    = r_halted;
  assign seq_bus.fault     = r_fault;

`ifdef CPU_SEQ_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_retired_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count   <= '0;
      r_retired_count <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (r_state == S_WRITEBACK) begin
        r_retired_count <= r_retired_count + 32'd1;
      end
    end
  end

  assign seq_bus.cycle_count   = r_cycle_count;
  assign seq_bus.retired_count = r_retired_count;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// The bench plays the datapath (PC, instruction register, register file, ALU,
// instruction memory with programmable wait states) around cpu_sequencer, and
// compares the outcome of each program against an instruction-level model.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int MEM_TIMEOUT = 15;
  localparam int MEM_WORDS   = 16;
  localparam int RUN_BUDGET  = 400;

  logic clock = 1'b0;
  logic reset;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock   (clock),
    .reset   (reset),
    .seq_bus (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Program and wait-state plan (waits[k] = idle cycles before ready on fetch k).
  logic [31:0] mem   [MEM_WORDS];
  int          waits [MEM_WORDS + 1];

  // Datapath state owned by the bench.
  logic [31:0] dp_regs [32];
  logic [31:0] dp_pc;
  logic [31:0] dp_ir;
  int          fetch_idx;
  bit          fetch_busy;
  int          wait_left;

  // Observations of the current run.
  int obs_busy, obs_pc_inc, obs_reg_we, obs_viol, obs_first_wb, obs_first_irload;

  // Instruction-level model results.
  logic [31:0] m_regs [32];
  int          m_cycles, m_retired, m_writes, m_fault;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    if (pc[31:2] < MEM_WORDS) return mem[pc[5:2]];
    return 32'h0;
  endfunction

  function automatic int wait_of(input int k);
    if (k < MEM_WORDS + 1) return waits[k];
    return 0;
  endfunction

  // ---------------------------------------------------------------- model
  task automatic model_run();
    logic [31:0] pc, w, a, b;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          k;
    bit          is_add, is_sub, is_addi;
    pc = 0; k = 0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    m_cycles = 0; m_retired = 0; m_writes = 0; m_fault = 0;
    while (1) begin
      if (wait_of(k) >= MEM_TIMEOUT) begin
        m_cycles += MEM_TIMEOUT;
        m_fault   = 2;
        break;
      end
      m_cycles += wait_of(k) + 2;          // fetch incl. ready cycle, then decode
      k++;
      w  = word_at(pc);
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      if (w == 32'h0) break;
      is_add  = (op == 7'h33) && (f3 == 3'd0) && (f7 == 7'h00);
      is_sub  = (op == 7'h33) && (f3 == 3'd0) && (f7 == 7'h20);
      is_addi = (op == 7'h13) && (f3 == 3'd0);
      if (!(is_add || is_sub || is_addi)) begin
        m_fault = 1;
        break;
      end
      m_cycles += 2;                        // execute + writeback
      a = m_regs[w[19:15]];
      b = is_addi ? {{20{w[31]}}, w[31:20]} : m_regs[w[24:20]];
      if (w[11:7] != 5'd0) begin
        m_regs[w[11:7]] = is_sub ? (a - b) : (a + b);
        m_writes++;
      end
      m_retired++;
      pc += 4;
    end
  endtask

  // ------------------------------------------------------------ datapath
  task automatic dp_clear();
    for (int r = 0; r < 32; r++) dp_regs[r] = 32'h0;
    dp_pc = 0; dp_ir = 0; bus.instruction = 32'h0;
    fetch_idx = 0; fetch_busy = 0; wait_left = 0;
    obs_busy = 0; obs_pc_inc = 0; obs_reg_we = 0; obs_viol = 0;
    obs_first_wb = -1; obs_first_irload = -1;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1 time unit
  // later, then apply what the datapath does at the coming rising edge.
  task automatic tick(input logic st);
    logic [31:0] a, b;
    @(negedge clock);
    bus.start = st;
    if (bus.instr_req) begin
      if (!fetch_busy) begin
        fetch_busy = 1;
        wait_left  = wait_of(fetch_idx);
        fetch_idx++;
      end
      if (wait_left > 0) begin
        bus.instr_ready = 1'b0;
        wait_left--;
      end else begin
        bus.instr_ready = 1'b1;
      end
    end else begin
      bus.instr_ready = 1'($urandom_range(0, 1));
    end
    #1;
    if (bus.ir_load !== (bus.instr_req & bus.instr_ready)) obs_viol++;
    if (bus.reg_we && !bus.pc_inc) obs_viol++;
    if (bus.instr_req && (bus.reg_we || bus.pc_inc)) obs_viol++;
    if (bus.halted && (bus.instr_req || bus.pc_inc || bus.alu_op != ALU_NONE)) obs_viol++;
    if (!bus.halted) obs_busy++;
    if (bus.ir_load) begin
      if (obs_first_irload < 0) obs_first_irload = obs_busy;
      dp_ir           = word_at(dp_pc);
      bus.instruction = dp_ir;
      fetch_busy      = 0;
    end
    if (bus.reg_we) begin
      a = dp_regs[dp_ir[19:15]];
      b = bus.use_imm ? {{20{dp_ir[31]}}, dp_ir[31:20]} : dp_regs[dp_ir[24:20]];
      dp_regs[dp_ir[11:7]] = (bus.alu_op == ALU_SUB) ? (a - b) : (a + b);
      obs_reg_we++;
    end
    if (bus.pc_inc) begin
      if (obs_first_wb < 0) obs_first_wb = obs_busy;
      dp_pc += 4;
      obs_pc_inc++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    fetch_busy = 0;
  endtask

  task automatic clear_program();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    for (int i = 0; i < MEM_WORDS + 1; i++) waits[i] = 0;
  endtask

  // Reset, start, run to HALT and compare against the model.
  task automatic run_program(input string tag, input bit rand_start);
    apply_reset();
    dp_clear();
    model_run();
    tick(1'b1);
    obs_busy = 0;
    for (int c = 0; c < RUN_BUDGET && !bus.halted; c++) begin
      tick(rand_start ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    check({tag, "_halted"},   32'(bus.halted),  32'd1);
    check({tag, "_fault"},    32'(bus.fault),   32'(m_fault));
    check({tag, "_cycles"},   32'(obs_busy),    32'(m_cycles));
    check({tag, "_pc_inc"},   32'(obs_pc_inc),  32'(m_retired));
    check({tag, "_reg_we"},   32'(obs_reg_we),  32'(m_writes));
    check({tag, "_protocol"}, 32'(obs_viol),    32'd0);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("%s_x%0d", tag, r), dp_regs[r], m_regs[r]);
    end
`ifdef CPU_SEQ_PERF_EN
    check({tag, "_cycle_count"},   bus.cycle_count,   32'(m_cycles));
    check({tag, "_retired_count"}, bus.retired_count, 32'(m_retired));
`endif
    repeat (3) tick(1'b1);
    check({tag, "_stay_halted"}, 32'(bus.halted),    32'd1);
    check({tag, "_fault_sticky"}, 32'(bus.fault),    32'(m_fault));
    check({tag, "_no_req_halt"}, 32'(bus.instr_req), 32'd0);
  endtask

  function automatic logic [31:0] rand_legal();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    case ($urandom_range(0, 2))
      0:       return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      1:       return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      default: return {imm, rs1, 3'b000, rd, 7'b0010011};
    endcase
  endfunction

  function automatic logic [31:0] rand_illegal();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_006f;   // jal
      1:       return 32'h0220_8033;   // mul
      2:       return 32'h0020_9093;   // slli
      3:       return 32'h0000_2083;   // lw
      default: return 32'h0020_c033;   // xor
    endcase
  endfunction

  logic [9:0] out_vec;

  initial begin
    bus.start = 1'b0;
    bus.instr_ready = 1'b1;
    bus.instruction = 32'h0;
    reset = 1'b0;
    clear_program();
    dp_clear();

    // Reset state, with instr_ready high to show ir_load stays low in reset.
    #12;
    out_vec = {bus.instr_req, bus.ir_load, bus.pc_inc, bus.reg_we,
               bus.alu_op, bus.use_imm, bus.halted, bus.fault};
    check("reset_outputs", 32'(out_vec), 32'd0);
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check("idle_no_req",    32'(bus.instr_req), 32'd0);
    check("idle_no_halted", 32'(bus.halted),    32'd0);

    // Three-instruction program, zero-wait memory.
    clear_program();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8233;
    mem[2] = 32'h4012_02b3;
    run_program("prog3", 1'b1);
    check("prog3_x1", dp_regs[1], 32'd5);
    check("prog3_x4", dp_regs[4], 32'd10);
    check("prog3_x5", dp_regs[5], 32'd5);
    check("prog3_first_wb", 32'(obs_first_wb), 32'd4);

    // Same program, first fetch delayed by three cycles.
    waits[0] = 3;
    run_program("prog3_wait3", 1'b0);
    check("wait3_ir_load_cycle", 32'(obs_first_irload), 32'd4);
    check("wait3_first_wb",      32'(obs_first_wb),     32'd7);

    // Write to x0 is suppressed but the PC still advances.
    clear_program();
    mem[0] = 32'h0070_0013;
    run_program("addi_x0", 1'b1);
    check("addi_x0_we",  32'(obs_reg_we), 32'd0);
    check("addi_x0_inc", 32'(obs_pc_inc), 32'd1);
    check("addi_x0_x0",  dp_regs[0],      32'd0);

    // Illegal instruction.
    clear_program();
    mem[0] = 32'h0000_006f;
    run_program("jal", 1'b1);
    check("jal_fault", 32'(bus.fault),  32'(FAULT_ILLEGAL));
    check("jal_no_inc", 32'(obs_pc_inc), 32'd0);

    // Memory timeout, and ready arriving on the last allowed cycle.
    clear_program();
    mem[0] = 32'h0050_0093;
    waits[0] = 99;
    run_program("timeout", 1'b0);
    check("timeout_fault",  32'(bus.fault), 32'(FAULT_TIMEOUT));
    check("timeout_cycles", 32'(obs_busy),  32'd15);
    waits[0] = 14;
    run_program("ready_at_15", 1'b0);
    check("ready_at_15_fault", 32'(bus.fault), 32'(FAULT_NONE));
    check("ready_at_15_x1",    dp_regs[1],     32'd5);

    // Reset asserted during EXECUTE of the add.
    clear_program();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8233;
    mem[2] = 32'h4012_02b3;
    apply_reset();
    dp_clear();
    tick(1'b1);
    begin
      bit found;
      found = 0;
      for (int c = 0; c < 50 && !found; c++) begin
        tick(1'b0);
        if (obs_pc_inc == 1 && bus.alu_op == ALU_ADD && !bus.pc_inc && !bus.use_imm) found = 1;
      end
      check("rst_mid_found_execute", 32'(found), 32'd1);
    end
    reset = 1'b0;
    #1;
    out_vec = {bus.instr_req, bus.ir_load, bus.pc_inc, bus.reg_we,
               bus.alu_op, bus.use_imm, bus.halted, bus.fault};
    check("rst_mid_outputs", 32'(out_vec), 32'd0);
    fetch_busy = 0;
    tick(1'b0);
    tick(1'b0);
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check("rst_mid_x4_unwritten", dp_regs[4],          32'd0);
    check("rst_mid_x1_kept",      dp_regs[1],          32'd5);
    check("rst_mid_idle_no_req",  32'(bus.instr_req),  32'd0);
    check("rst_mid_idle_halted",  32'(bus.halted),     32'd0);
    // Restart from the retained PC (the add) and run to the end.
    tick(1'b1);
    tick(1'b0);
    check("rst_mid_restart_req", 32'(bus.instr_req), 32'd1);
    for (int c = 0; c < RUN_BUDGET && !bus.halted; c++) tick(1'b0);
    check("rst_mid_rerun_x4",    dp_regs[4],      32'd10);
    check("rst_mid_rerun_x5",    dp_regs[5],      32'd5);
    check("rst_mid_rerun_fault", 32'(bus.fault),  32'd0);

    // Randomized programs and wait states.
    for (int t = 0; t < 25; t++) begin
      int n;
      clear_program();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) mem[i] = rand_legal();
      if ($urandom_range(0, 2) == 0) mem[n] = rand_illegal();
      for (int i = 0; i < MEM_WORDS + 1; i++) begin
        waits[i] = ($urandom_range(0, 11) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
      end
      run_program($sformatf("rand%0d", t), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
